// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared Ascon types, round-constant table and sequencer FSM encoding
// Purpose: single source for the 5x64 state type, the round index type, the
//          16-entry round-constant table (also consumed by the constant-addition
//          layer), standard round counts and the sequencer state enum.
// Ports:   none (package).
package ascon_pkg;

    // Word 0 is x0, word 4 is x4.
    typedef logic [4:0][63:0] ascon_state_t;
    typedef logic [3:0]       rnd_t;

    localparam int ASCON_MAX_ROUNDS = 16;
    localparam int ASCON_PA_ROUNDS  = 12;
    localparam int ASCON_PB_ROUNDS  = 8;

    // Constant for round index i; p[nr] uses indices 16-nr..15.
    localparam logic [7:0] ASCON_RC [0:15] = '{
        8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
        8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round (constant add, S-box, linear diffusion)
// Purpose: applies round index i_rnd to i_state.
// Ports:   i_state - input state
//          i_rnd   - round index selecting the round constant
//          o_state - state after the round
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t i_state,
    input  rnd_t         i_rnd,
    output ascon_state_t o_state
);

    logic [63:0] w_x2_ca;
    logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
    logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;
    logic [63:0] w_s0, w_s1, w_s2, w_s3, w_s4;

    // Constant addition touches only the low byte of x2.
    assign w_x2_ca = i_state[2] ^ {56'd0, ASCON_RC[i_rnd]};

    // Bitsliced 5-bit S-box applied to all 64 columns in parallel.
    assign w_a0 = i_state[0] ^ i_state[4];
    assign w_a1 = i_state[1];
    assign w_a2 = w_x2_ca ^ i_state[1];
    assign w_a3 = i_state[3];
    assign w_a4 = i_state[4] ^ i_state[3];

    assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
    assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
    assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
    assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
    assign w_b4 = w_a4 ^ (~w_a0 & w_a1);

    assign w_s0 = w_b0 ^ w_b4;
    assign w_s1 = w_b1 ^ w_b0;
    assign w_s2 = ~w_b2;
    assign w_s3 = w_b3 ^ w_b2;
    assign w_s4 = w_b4;

    // Linear diffusion, per-word rotation pairs.
    assign o_state[0] = w_s0 ^ rotr64(w_s0, 19) ^ rotr64(w_s0, 28);
    assign o_state[1] = w_s1 ^ rotr64(w_s1, 61) ^ rotr64(w_s1, 39);
    assign o_state[2] = w_s2 ^ rotr64(w_s2, 1)  ^ rotr64(w_s2, 6);
    assign o_state[3] = w_s3 ^ rotr64(w_s3, 10) ^ rotr64(w_s3, 17);
    assign o_state[4] = w_s4 ^ rotr64(w_s4, 7)  ^ rotr64(w_s4, 41);

endmodule

// File: rtl/ascon_permutation_sequencer.sv
// rtl/ascon_permutation_sequencer.sv - iterative Ascon-p[nr] engine issuing round indices
// Purpose: accepts a state and round count, runs UNROLL rounds per clock
//          through chained ascon_round instances, returns the permuted state.
// Parameter: UNROLL (1, 2 or 4) rounds per clock.
// Macro:   ASCON_PERM_NR_CHECK_EN adds err_o and illegal-nr bypass.
// Ports:   clk_i, rst_i (sync, active high)
//          in_valid_i/in_ready_o, state_i, nr_i - request
//          out_valid_o/out_ready_i, state_o     - result
//          rnd_o  - first round index applied this cycle
//          busy_o - engine not idle
//          err_o  - illegal nr_i (only with ASCON_PERM_NR_CHECK_EN)
module ascon_permutation_sequencer
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  ascon_state_t state_i,
    input  logic [4:0]   nr_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_o,
    output rnd_t         rnd_o,
    output logic         busy_o
`ifdef ASCON_PERM_NR_CHECK_EN
    ,
    output logic         err_o
`endif
);

    seq_state_t   r_fsm;
    seq_state_t   w_fsm_nxt;
    ascon_state_t r_state;
    rnd_t         r_rnd;
    logic [4:0]   r_rem;
    logic         w_last;
    logic         w_illegal;
    ascon_state_t w_chain [UNROLL+1];

    assign w_last = (r_rem == 5'(UNROLL));

`ifdef ASCON_PERM_NR_CHECK_EN
    logic r_err;
    assign w_illegal = (nr_i == 5'd0) || (nr_i > 5'd16) || ((nr_i & 5'(UNROLL - 1)) != 5'd0);
    assign err_o     = r_err;
`else
    assign w_illegal = 1'b0;
`endif

    assign w_chain[0] = r_state;

    generate
        for (genvar g = 0; g < UNROLL; g++) begin : g_round
            ascon_round u_round (
                .i_state (w_chain[g]),
                .i_rnd   (r_rnd + rnd_t'(g)),
                .o_state (w_chain[g+1])
            );
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (r_fsm)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (in_valid_i) begin
                    w_fsm_nxt = w_illegal ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_fsm_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_fsm_nxt = ST_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= '0;
            r_rnd   <= '0;
            r_rem   <= '0;
`ifdef ASCON_PERM_NR_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_state <= state_i;
                        if (!w_illegal) begin
                            // -nr mod 16 == 16-nr truncated; nr=0 thus starts at index 0.
                            r_rnd <= 4'd0 - nr_i[3:0];
                            // nr=0 runs the full 16 rounds.
                            r_rem <= (nr_i == 5'd0) ? 5'd16 : nr_i;
                        end
`ifdef ASCON_PERM_NR_CHECK_EN
                        r_err <= w_illegal;
`endif
                    end
                end
                ST_RUN: begin
                    r_state <= w_chain[UNROLL];
                    r_rem   <= r_rem - 5'(UNROLL);
                    // Leave rnd_o on the last index issued while the result waits.
                    if (!w_last) begin
                        r_rnd <= r_rnd + rnd_t'(UNROLL);
                    end
                end
                ST_DONE: begin
`ifdef ASCON_PERM_NR_CHECK_EN
                    if (out_ready_i) begin
                        r_err <= 1'b0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign state_o = r_state;
    assign rnd_o   = r_rnd;

endmodule
